// File: rtl/my_ram_n.sv
// my_ram_n: WIDTH x DEPTH RAM with a one-entry-per-cycle hardware clear sweep after reset or clear.
// Defining MY_RAM_N_OUT_REG_EN registers the read port, giving it one cycle of latency.
module my_ram_n #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n, wa;
  logic [WIDTH-1:0] wd;
  logic we;
  logic [WIDTH-1:0] mem [DEPTH];
  assign busy = (state == CLEAR);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    we      = 1'b0;
    wa      = addr;
    wd      = in;
    if (state == CLEAR) begin
      we      = 1'b1;
      wa      = cnt;
      wd      = '0;
      cnt_n   = cnt + 1'b1;
      state_n = (cnt == ADDR_W'(DEPTH - 1)) ? IDLE : CLEAR;
    end else if (clear) begin
      state_n = CLEAR;
      cnt_n   = '0;
    end else if (load) begin
      we = 1'b1;
    end
  end
  // The array has no reset; the sweep is the only thing that zeroes it.
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
`ifdef MY_RAM_N_OUT_REG_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) out <= '0;
    else out <= busy ? '0 : mem[addr];
`else
  assign out = busy ? '0 : mem[addr];
`endif
endmodule
